// File: rtl/ram_fifo.sv
// ram_fifo: synchronous FIFO built on a DEPTH x DATA_WIDTH register array.
// Registered read data arrives one cycle after an accepted read and is flagged
// by rd_valid. full/empty are registered copies of the next count.
// Optional feature macro: RAM_FIFO_ERR_FLAGS_EN adds the sticky err_ovf/err_udf
// outputs. The default build (macro undefined) leaves those ports out entirely.
module ram_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef RAM_FIFO_ERR_FLAGS_EN
  ,
  output logic                  err_ovf,
  output logic                  err_udf
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] rdData_q;
  logic                  rdValid_q;

  logic wrAccept;
  logic rdAccept;

  // Requests are only honoured against the registered flags, so an empty FIFO
  // never lets a same-cycle write fall through to the read side, and a full
  // FIFO drops the write even when a read frees a slot in that same cycle.
  always_comb begin
    wrAccept = wr_en & ~full_q;
    rdAccept = rd_en & ~empty_q;
  end

  // Next-state for pointers, occupancy and the flags derived from it.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (wrAccept) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (rdAccept) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (wrAccept && !rdAccept) begin
      count_d = count_q + 1'b1;
    end else if (rdAccept && !wrAccept) begin
      count_d = count_q - 1'b1;
    end
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  // Control state register; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      rdValid_q <= rdAccept;
      if (rdAccept) begin
        rdData_q <= mem[rdPtr_q];
      end
    end
  end

  // Storage array: written only on accepted writes, never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && wrAccept) begin
      mem[wrPtr_q] <= wr_data;
    end
  end

  assign rd_data  = rdData_q;
  assign rd_valid = rdValid_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

`ifdef RAM_FIFO_ERR_FLAGS_EN
  logic errOvf_q, errOvf_d;
  logic errUdf_q, errUdf_d;

  // Sticky flags record any request made against the wrong registered flag;
  // a simultaneous read does not excuse a write attempted while full.
  always_comb begin
    errOvf_d = errOvf_q | (wr_en & full_q);
    errUdf_d = errUdf_q | (rd_en & empty_q);
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      errOvf_q <= 1'b0;
      errUdf_q <= 1'b0;
    end else begin
      errOvf_q <= errOvf_d;
      errUdf_q <= errUdf_d;
    end
  end

  assign err_ovf = errOvf_q;
  assign err_udf = errUdf_q;
`endif

endmodule

// File: doc/ram_fifo.md
RAM_FIFO -- requirements
Module: ram_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, log2 of storage depth (DEPTH = 2**ADDR_WIDTH entries).
REQ-002 SHALL have parameter DATA_WIDTH, default 4, bits per entry.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  write request.
REQ-006 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-007 SHALL have port rd_en  input  1  read request.
REQ-008 SHALL have port rd_data  output  DATA_WIDTH  registered read data.
REQ-009 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data updated this cycle.
REQ-010 SHALL have port full  output  1  count == DEPTH.
REQ-011 SHALL have port empty  output  1  count == 0.
REQ-012 SHALL have port count  output  ADDR_WIDTH+1  stored entries, 0..DEPTH.
REQ-013 SHALL have ports err_ovf and err_udf  output  1 each  sticky error flags (present only per REQ-032).

Function
REQ-014 Storage SHALL be a DEPTH x DATA_WIDTH synchronous-write array; contents are not reset.
REQ-015 Write SHALL be accepted iff wr_en=1 and full=0; the entry is stored at wr_ptr and wr_ptr increments.
REQ-016 Read SHALL be accepted iff rd_en=1 and empty=0; mem[rd_ptr] is registered into rd_data and rd_ptr increments.
REQ-017 Read latency SHALL be one cycle: rd_data and rd_valid=1 valid the cycle after the accepting edge.
REQ-018 rd_valid SHALL be 0 in every cycle not following an accepted read; rd_data SHALL hold its last value.
REQ-019 wr_ptr and rd_ptr SHALL be ADDR_WIDTH bits and wrap from DEPTH-1 to 0.
REQ-020 count SHALL +1 on write-only accept, -1 on read-only accept, unchanged on both-accept or neither.
REQ-021 full and empty SHALL be registered, derived from next count, valid the cycle after the update.
REQ-022 Empty with wr_en=1 and rd_en=1: write accepted, read rejected (no fall-through); count 0->1.
REQ-023 Full with wr_en=1 and rd_en=1: read accepted, write rejected; count DEPTH->DEPTH-1.
REQ-024 Neither empty nor full with both requests: both accepted, count unchanged; a read never returns data written in the same cycle.
REQ-025 Rejected requests SHALL not change pointers, count, memory, or rd_data.

Reset
REQ-026 rst=1 at a rising edge SHALL set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, rd_data=0, err_ovf=0, err_udf=0.
REQ-027 rst SHALL dominate wr_en/rd_en in the same cycle; no request in a reset cycle is accepted.
REQ-028 Reset mid-operation SHALL discard all stored entries; first post-reset read request with empty=1 is rejected.
REQ-029 Memory array contents SHALL be left unchanged by reset.

Configuration
REQ-030 Macro RAM_FIFO_ERR_FLAGS_EN SHALL control presence of error flags.
REQ-031 With RAM_FIFO_ERR_FLAGS_EN defined: err_ovf sets on wr_en=1 with full=1 (not saved by a simultaneous read), err_udf sets on rd_en=1 with empty=1; both stay 1 until rst.
REQ-032 Without RAM_FIFO_ERR_FLAGS_EN: err_ovf and err_udf ports SHALL be absent; all other behaviour identical.

Verification (ADDR_WIDTH=4, DATA_WIDTH=4)
REQ-033 Reset, write 0x3,0x7,0xA, then 3 reads -> rd_data 0x3,0x7,0xA each one cycle after its read edge with rd_valid=1; count 3->0; empty=1.
REQ-034 16 writes 0x0..0xF -> full=1, count=16; 17th write 0x5 rejected (err_ovf=1 if enabled); 16 reads return 0x0..0xF in order.
REQ-035 Empty, wr_en=rd_en=1 with 0x9 -> rd_valid=0 next cycle, count=1; next read returns 0x9.
REQ-036 Full, wr_en=rd_en=1 with 0xC -> read accepted, write dropped, count=15; remaining reads never return 0xC.
REQ-037 Write 12, read 12, write 10 (pointers wrap past 15) -> 10 reads return written data in order; count returns to 0.
REQ-038 Count 5, rst=1 with wr_en=rd_en=1 -> next cycle count=0, empty=1, rd_valid=0, rd_data=0, flags 0; subsequent read with rd_en=1 rejected (err_udf=1 if enabled).
